ulpi_tx_packet: RTL
===================

// Module: ulpi_tx_packet
// PURPOSE
//  Link-side ULPI packet transmitter, the transmit counterpart of the ULPI receive path.
//  - Takes a PID plus a byte stream from an upstream buffer.
//  - Issues the ULPI TX CMD (PID transmit), streams bytes paced by NXT, then ends with STP.
//  - Sits beside the register read/write engines under the ULPI master controller.
//  - The controller grants the bus via start while idle; DATA_O/STP are muxed on busy.
// PARAMETERS
//  MAX_LEN  1024  max payload bytes after the PID byte; exceeding it forces an abort
//  CNT_W    11    byte-counter width; must satisfy 2**CNT_W > MAX_LEN
// PORTS
//  clk_ULPI   in   1   60MHz ULPI clock, the only clock
//  rst        in   1   asynchronous, active-low reset
//  start      in   1   request to send one packet; sampled only in S_IDLE
//  PID        in   4   USB PID, latched on accepted start
//  pid_only   in   1   handshake packet (no payload), latched on accepted start
//  tx_data    in   8   payload byte from upstream buffer
//  tx_valid   in   1   tx_data valid
//  tx_last    in   1   tx_data is final payload byte
//  tx_ready   out  1   byte consumed this cycle (valid&ready transfer)
//  busy       out  1   high in every state except S_IDLE
//  done       out  1   1-cycle pulse: packet completed with normal STP
//  error      out  1   1-cycle pulse: packet aborted; cause in err_code
//  err_code   out  2   01 PHY took bus (DIR), 10 underrun, 11 overlength; holds until next start
//  DIR        in   1   ULPI DIR
//  NXT        in   1   ULPI NXT
//  DATA_O     out  8   ULPI data driven by link (top level tristates on DIR)
//  STP        out  1   ULPI STP
// BEHAVIOUR
//  - Reset: state S_IDLE; DATA_O=0, STP=0, tx_ready=0, busy=0, done=0, error=0, err_code=0, byte count=0.
//  - dir_q is a registered copy of DIR, used to enforce the turnaround cycle.
//  - Start accepted when start & !DIR & !dir_q in S_IDLE.
//    - Accept latches PID and pid_only, clears count and err_code, then -> S_TXCMD.
//    - Otherwise start is ignored; no queuing.
//  - S_TXCMD: DATA_O={2'b01,2'b00,PID}, STP=0.
//    - DIR high: -> S_WAIT (retry pending, no error).
//    - NXT high: -> S_STOP if pid_only, else -> S_DATA.
//  - S_WAIT: DATA_O=0.
//    - -> S_TXCMD once DIR=0 and dir_q=0, which guarantees one turnaround cycle.
//  - S_DATA: DATA_O=tx_data (combinational, zero latency); tx_ready = NXT & tx_valid & !DIR.
//    - DIR high: -> S_IDLE, error=1, err_code=01. No STP, since the PHY owns the bus.
//    - NXT & !tx_valid: -> S_ABORT, err_code=10.
//    - transfer & tx_last: -> S_STOP.
//    - transfer & count==MAX_LEN-1 & !tx_last: -> S_ABORT, err_code=11.
//    - transfer (otherwise): count+1, stay in S_DATA.
//    - !NXT: hold the same byte; tx_ready=0.
//  - S_STOP: STP=1, DATA_O=0 for exactly 1 cycle; then -> S_IDLE with done=1 on that edge.
//  - S_ABORT: STP=1, DATA_O=8'hFF for 1 cycle (ULPI transmit abort); then -> S_IDLE with error=1.
//  - done and error are never high together; each is registered and asserted the cycle after STP.
//  - Simultaneous DIR and NXT in S_TXCMD or S_DATA: DIR wins.
//  - Reset mid-packet: immediate return to reset values; no STP is generated.
//  - Count saturates at MAX_LEN; no wrap.
// STRUCTURE
//  - Shared header ULPI_defs.vh holds:
//    - state encodings S_IDLE, S_TXCMD, S_WAIT, S_DATA, S_STOP, S_ABORT;
//    - TXCMD_PID prefix 2'b01;
//    - ERR_* codes;
//    - ULPI_ABORT_BYTE 8'hFF.
//  - Single module, no sub-module: one FSM, one CNT_W counter, PID/pid_only/dir_q/err_code registers.
// TESTING
//  1. PID=4'h3, 3 bytes 11/22/33, NXT high every cycle after TXCMD:
//     DATA_O = 8'h43, 11, 22, 33; STP=1 with DATA_O=0 one cycle; done pulse; busy low after.
//  2. pid_only=1, PID=4'h2, NXT on cycle 2:
//     DATA_O=8'h42 held until NXT, then STP one cycle, done=1, tx_ready never high.
//  3. DIR rises during TXCMD (before NXT), drops 4 cycles later:
//     S_WAIT, TXCMD re-issued no earlier than 2 cycles after DIR falls; no error.
//  4. DIR rises after 2nd payload byte:
//     error=1, err_code=01, STP stays 0, state S_IDLE the next cycle.
//  5. tx_valid drops while NXT=1:
//     STP=1 with DATA_O=8'hFF one cycle, error=1, err_code=10.
//     MAX_LEN=4 with 5 bytes, no tx_last by byte 4: abort with err_code=11.
//  6. rst low mid-S_DATA:
//     all outputs 0 asynchronously; start after release is accepted only when DIR=0 for 2 cycles.

Source files
------------

// File: rtl/ulpi_tx_packet_pkg.sv
// ULPI transmit packet engine shared definitions.
// State encodings, TX CMD prefix, error codes and abort byte.
package ulpi_tx_packet_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TXCMD,
        S_WAIT,
        S_DATA,
        S_STOP,
        S_ABORT
    } state_t;

    localparam logic [1:0] TXCMD_PID = 2'b01;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_DIR      = 2'b01;
    localparam logic [1:0] ERR_UNDERRUN = 2'b10;
    localparam logic [1:0] ERR_OVERLEN  = 2'b11;

    localparam logic [7:0] ULPI_ABORT_BYTE = 8'hFF;

    function automatic logic [7:0] txcmd_byte(input logic [3:0] pid);
        return {TXCMD_PID, 2'b00, pid};
    endfunction

endpackage

// File: rtl/ulpi_tx_packet.sv
// Link-side ULPI packet transmitter: TX CMD, NXT-paced payload, STP.
// Aborts on PHY bus grab, upstream underrun or overlength payload.
module ulpi_tx_packet
    import ulpi_tx_packet_pkg::*;
#(
    parameter int MAX_LEN = 1024,
    parameter int CNT_W   = 11
) (
    input  logic       clk_ULPI,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] PID,
    input  logic       pid_only,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    input  logic       DIR,
    input  logic       NXT,
    output logic [7:0] DATA_O,
    output logic       STP
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_LEN - 1);
    localparam logic [CNT_W-1:0] SAT_CNT  = CNT_W'(MAX_LEN);

    state_t           state;
    logic [3:0]       pid_q;
    logic             pid_only_q;
    logic             dir_q;
    logic [CNT_W-1:0] count;
    logic             xfer;

    // A payload byte moves only when the PHY asks for it and still owns nothing.
    assign xfer     = (state == S_DATA) && NXT && tx_valid && !DIR;
    assign tx_ready = xfer;
    assign busy     = (state != S_IDLE);

    // Bus drive follows state; payload passes straight through with no latency.
    always_comb begin
        DATA_O = 8'h00;
        STP    = 1'b0;
        unique case (state)
            S_TXCMD: DATA_O = txcmd_byte(pid_q);
            S_DATA:  DATA_O = tx_data;
            S_STOP:  STP    = 1'b1;
            S_ABORT: begin
                STP    = 1'b1;
                DATA_O = ULPI_ABORT_BYTE;
            end
            default: DATA_O = 8'h00;
        endcase
    end

    // Delayed DIR gives the mandatory turnaround cycle before driving.
    always_ff @(posedge clk_ULPI or negedge rst) begin
        if (!rst) dir_q <= 1'b0;
        else      dir_q <= DIR;
    end

    // Packet sequencer with byte counter and status pulses.
    always_ff @(posedge clk_ULPI or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            pid_q      <= 4'h0;
            pid_only_q <= 1'b0;
            count      <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start && !DIR && !dir_q) begin
                        pid_q      <= PID;
                        pid_only_q <= pid_only;
                        count      <= '0;
                        err_code   <= ERR_NONE;
                        state      <= S_TXCMD;
                    end
                end
                S_TXCMD: begin
                    if (DIR)      state <= S_WAIT;
                    else if (NXT) state <= pid_only_q ? S_STOP : S_DATA;
                end
                S_WAIT: begin
                    if (!DIR && !dir_q) state <= S_TXCMD;
                end
                S_DATA: begin
                    if (DIR) begin
                        state    <= S_IDLE;
                        error    <= 1'b1;
                        err_code <= ERR_DIR;
                    end else if (NXT && !tx_valid) begin
                        state    <= S_ABORT;
                        err_code <= ERR_UNDERRUN;
                    end else if (xfer) begin
                        if (tx_last) begin
                            state <= S_STOP;
                        end else if (count == LAST_IDX) begin
                            state    <= S_ABORT;
                            err_code <= ERR_OVERLEN;
                        end else if (count != SAT_CNT) begin
                            count <= count + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                end
                S_ABORT: begin
                    state <= S_IDLE;
                    error <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
